// File: rtl/soc_bus_pkg.sv
// ---------------------------------------------------------------------------
// soc_bus_pkg
//   Definitions shared by the APB request arbiter and its watchdog:
//   the arbiter FSM state encoding, the default store-strobe width, the
//   read-data pattern returned on a timed-out transfer, the requester port
//   indices, and the tie-break helper.
// ---------------------------------------------------------------------------
package soc_bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } arb_state_t;

    localparam int          STRB_W_DEF = 2;
    localparam logic [31:0] ERR_RDATA  = 32'hDEAD_BEEF;

    // Requester indices: port 0 = RV32I core, port 1 = UART RX drain/DMA.
    localparam logic PORT0 = 1'b0;
    localparam logic PORT1 = 1'b1;

    // Winner selection; only meaningful when at least one request is up.
    // A lone request always wins. On a tie, fixed priority favours port 0,
    // otherwise the round-robin pointer names the winner.
    function automatic logic pick_winner(input logic req0, input logic req1,
                                         input logic ptr, input logic fixed);
        if (req0 && req1) begin
            return fixed ? PORT0 : ptr;
        end
        return req1 ? PORT1 : PORT0;
    endfunction

endpackage

// File: rtl/apb_arb_watchdog.sv
// ---------------------------------------------------------------------------
// apb_arb_watchdog
//   Counts cycles spent waiting for the APB master. expire is raised during
//   the LIMIT-th enabled cycle after a clear, so a wait of exactly LIMIT
//   cycles is abandoned at the end of that cycle.
// Ports
//   CLK     in  clock, rising edge
//   RESET   in  asynchronous active-low reset
//   clear   in  restart the count (held while the arbiter is in ISSUE)
//   enable  in  count this cycle (arbiter is in WAIT)
//   expire  out limit reached this cycle (combinational)
// ---------------------------------------------------------------------------
module apb_arb_watchdog #(
    parameter int LIMIT = 256
) (
    input  logic CLK,
    input  logic RESET,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int          CW   = (LIMIT > 1) ? $clog2(LIMIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(LIMIT - 1);

    logic [CW-1:0] cnt;

    assign expire = enable && (cnt == LAST);

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (enable && !expire) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/apb_req_arbiter.sv
// ---------------------------------------------------------------------------
// apb_req_arbiter
//   Shares the single APB_Master request port between the RV32I core
//   (port 0) and the UART RX drain/DMA engine (port 1). One transfer at a
//   time: IDLE -> ISSUE -> WAIT -> DONE -> IDLE. The winner's payload is
//   copied into the M_* registers at grant, so later requester changes are
//   ignored. Read data and the DONE pulse go back to the winner only.
// Configuration
//   APB_ARB_TIMEOUT_EN : when defined, a watchdog abandons a WAIT lasting
//                        TIMEOUT_CYCLES cycles, returns 32'hDEAD_BEEF and
//                        pulses ERRx with DONEx. Undefined: WAIT is unbounded
//                        and ERR0/ERR1 stay 0.
// Ports
//   CLK, RESET               clock / asynchronous active-low reset
//   REQx, WRx, ADDRx,
//   WDATAx, STRBx            requester x: request and payload (held to DONEx)
//   GNTx                     high from issue until DONEx inclusive
//   DONEx, ERRx              one-cycle completion / timeout pulses
//   RDATA                    load data, valid with DONEx, held until next load
//   M_TRANS_EN, M_WR_EN,
//   M_ADDR, M_WDATA, M_STRB  registered request towards APB_Master
//   M_TRANS_DONE, M_RDATA    completion and read data from APB_Master
// ---------------------------------------------------------------------------
module apb_req_arbiter
    import soc_bus_pkg::*;
#(
    parameter int WIDTH          = 32,
    parameter int STRB_W         = STRB_W_DEF,
    parameter int FIXED_PRIO     = 0,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              REQ0,
    input  logic              REQ1,
    input  logic              WR0,
    input  logic              WR1,
    input  logic [WIDTH-1:0]  ADDR0,
    input  logic [WIDTH-1:0]  ADDR1,
    input  logic [WIDTH-1:0]  WDATA0,
    input  logic [WIDTH-1:0]  WDATA1,
    input  logic [STRB_W-1:0] STRB0,
    input  logic [STRB_W-1:0] STRB1,
    output logic              GNT0,
    output logic              GNT1,
    output logic              DONE0,
    output logic              DONE1,
    output logic              ERR0,
    output logic              ERR1,
    output logic [WIDTH-1:0]  RDATA,
    output logic              M_TRANS_EN,
    output logic              M_WR_EN,
    output logic [WIDTH-1:0]  M_ADDR,
    output logic [WIDTH-1:0]  M_WDATA,
    output logic [STRB_W-1:0] M_STRB,
    input  logic              M_TRANS_DONE,
    input  logic [WIDTH-1:0]  M_RDATA
);

    arb_state_t state;
    logic       ptr;      // round-robin: port that wins the next tie
    logic       owner;    // port currently granted
    logic       winner;
    logic       timeout;

    assign winner = pick_winner(REQ0, REQ1, ptr, FIXED_PRIO != 0);

`ifdef APB_ARB_TIMEOUT_EN
    // Cleared during ISSUE so the count starts at zero on entry to WAIT.
    apb_arb_watchdog #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_watchdog (
        .CLK    (CLK),
        .RESET  (RESET),
        .clear  (state == ST_ISSUE),
        .enable (state == ST_WAIT),
        .expire (timeout)
    );
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
    assign timeout            = 1'b0;
`endif

    // NOTE: every register here updates with <= so all right-hand sides see
    // the pre-edge values; blocking assignments would make the result depend
    // on statement order and break the registered-output timing.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state      <= ST_IDLE;
            ptr        <= PORT0;
            owner      <= PORT0;
            GNT0       <= 1'b0;
            GNT1       <= 1'b0;
            DONE0      <= 1'b0;
            DONE1      <= 1'b0;
            ERR0       <= 1'b0;
            ERR1       <= 1'b0;
            RDATA      <= '0;
            M_TRANS_EN <= 1'b0;
            M_WR_EN    <= 1'b0;
            M_ADDR     <= '0;
            M_WDATA    <= '0;
            M_STRB     <= '0;
        end else begin
            // Pulses last one cycle unless re-asserted below.
            DONE0 <= 1'b0;
            DONE1 <= 1'b0;
            ERR0  <= 1'b0;
            ERR1  <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (REQ0 || REQ1) begin
                        owner      <= winner;
                        GNT0       <= (winner == PORT0);
                        GNT1       <= (winner == PORT1);
                        M_WR_EN    <= (winner == PORT1) ? WR1    : WR0;
                        M_ADDR     <= (winner == PORT1) ? ADDR1  : ADDR0;
                        M_WDATA    <= (winner == PORT1) ? WDATA1 : WDATA0;
                        M_STRB     <= (winner == PORT1) ? STRB1  : STRB0;
                        // Raised here so transEn is visible during ISSUE,
                        // one cycle after the request is sampled.
                        M_TRANS_EN <= 1'b1;
                        state      <= ST_ISSUE;
                    end
                end

                // trans_done is deliberately not looked at in ISSUE.
                ST_ISSUE: state <= ST_WAIT;

                ST_WAIT: begin
                    // A real completion takes precedence over a coincident timeout.
                    if (M_TRANS_DONE || timeout) begin
                        M_TRANS_EN <= 1'b0;
                        if (M_TRANS_DONE) begin
                            if (!M_WR_EN) begin
                                RDATA <= M_RDATA;
                            end
                        end else begin
                            RDATA <= WIDTH'(ERR_RDATA);
                            ERR0  <= (owner == PORT0);
                            ERR1  <= (owner == PORT1);
                        end
                        DONE0 <= (owner == PORT0);
                        DONE1 <= (owner == PORT1);
                        ptr   <= ~owner;
                        state <= ST_DONE;
                    end
                end

                ST_DONE: begin
                    GNT0  <= 1'b0;
                    GNT1  <= 1'b0;
                    state <= ST_IDLE;
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_apb_req_arbiter.sv
// ---------------------------------------------------------------------------
// tb_apb_req_arbiter
//   Self-checking bench for apb_req_arbiter: a table of single-requester
//   transfers, hand-written multi-cycle sequences (arbitration order for
//   both priority modes, async reset mid-transfer, stray trans_done, and the
//   watchdog when APB_ARB_TIMEOUT_EN is defined), then randomized traffic
//   checked against a transfer-timeline model.
// ---------------------------------------------------------------------------
module tb_apb_req_arbiter;

    localparam int W  = 32;
    localparam int SW = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic          req0, req1, wr0, wr1;
    logic [W-1:0]  addr0, addr1, wdata0, wdata1;
    logic [SW-1:0] strb0, strb1;
    logic          m_done, fp_m_done;
    logic [W-1:0]  m_rdata;

    logic          gnt0, gnt1, done0, done1, err0, err1, m_en, m_wr;
    logic [W-1:0]  rdata, m_addr, m_wdata;
    logic [SW-1:0] m_strb;

    logic          fp_gnt0, fp_gnt1, fp_done0, fp_done1, fp_err0, fp_err1, fp_en, fp_wr;
    logic [W-1:0]  fp_rdata, fp_addr, fp_wdata;
    logic [SW-1:0] fp_strb;

    apb_req_arbiter #(.WIDTH(W), .STRB_W(SW), .FIXED_PRIO(0), .TIMEOUT_CYCLES(8)) dut (
        .CLK(clk), .RESET(rst_n),
        .REQ0(req0), .REQ1(req1), .WR0(wr0), .WR1(wr1),
        .ADDR0(addr0), .ADDR1(addr1), .WDATA0(wdata0), .WDATA1(wdata1),
        .STRB0(strb0), .STRB1(strb1),
        .GNT0(gnt0), .GNT1(gnt1), .DONE0(done0), .DONE1(done1),
        .ERR0(err0), .ERR1(err1), .RDATA(rdata),
        .M_TRANS_EN(m_en), .M_WR_EN(m_wr), .M_ADDR(m_addr), .M_WDATA(m_wdata),
        .M_STRB(m_strb), .M_TRANS_DONE(m_done), .M_RDATA(m_rdata)
    );

    apb_req_arbiter #(.WIDTH(W), .STRB_W(SW), .FIXED_PRIO(1), .TIMEOUT_CYCLES(8)) dut_fp (
        .CLK(clk), .RESET(rst_n),
        .REQ0(req0), .REQ1(req1), .WR0(wr0), .WR1(wr1),
        .ADDR0(addr0), .ADDR1(addr1), .WDATA0(wdata0), .WDATA1(wdata1),
        .STRB0(strb0), .STRB1(strb1),
        .GNT0(fp_gnt0), .GNT1(fp_gnt1), .DONE0(fp_done0), .DONE1(fp_done1),
        .ERR0(fp_err0), .ERR1(fp_err1), .RDATA(fp_rdata),
        .M_TRANS_EN(fp_en), .M_WR_EN(fp_wr), .M_ADDR(fp_addr), .M_WDATA(fp_wdata),
        .M_STRB(fp_strb), .M_TRANS_DONE(fp_m_done), .M_RDATA(m_rdata)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Simple APB master stand-in: trans_done is raised resp_lat cycles after
    // transEn first appears.
    int en_cnt    = 0;
    int fp_cnt    = 0;
    int resp_lat  = 2;
    bit auto_resp = 1'b1;

    typedef struct {
        logic        port;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [1:0]  strb;
        int          lat;
        logic [31:0] mdata;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs[5];

    // Random-traffic model state: one transfer timeline (grant edge g,
    // master latency L) plus the round-robin pointer and expected M_* copies.
    int          k, g, L, free_from;
    bit          active;
    logic        owner_m, ptr_m;
    logic        e_wr;
    logic [31:0] e_addr, e_wdata, e_rdata;
    logic [1:0]  e_strb;
    logic        p_wr[2];
    logic [31:0] p_addr[2], p_wdata[2];
    logic [1:0]  p_strb[2];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [6:0] ctl();
        return {gnt1, gnt0, done1, done0, err1, err0, m_en};
    endfunction

    task automatic cycle();
        @(negedge clk);
        en_cnt = m_en  ? en_cnt + 1 : 0;
        fp_cnt = fp_en ? fp_cnt + 1 : 0;
        if (auto_resp) begin
            m_done    = (en_cnt == resp_lat);
            fp_m_done = (fp_cnt == resp_lat);
        end
    endtask

    task automatic drive_port(input logic p, input logic r, input logic w,
                              input logic [31:0] a, input logic [31:0] d, input logic [1:0] s);
        if (p) begin
            req1 = r; wr1 = w; addr1 = a; wdata1 = d; strb1 = s;
        end else begin
            req0 = r; wr0 = w; addr0 = a; wdata0 = d; strb0 = s;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req0 = 1'b0; req1 = 1'b0; m_done = 1'b0; fp_m_done = 1'b0;
        repeat (2) @(negedge clk);
        rst_n  = 1'b1;
        en_cnt = 0;
        fp_cnt = 0;
    endtask

    // One transfer from a single requester; payload is scrambled after the
    // grant to prove the registered copy is what reaches the master.
    task automatic run_vec(input int idx, input vec_t v);
        int          first_gnt = -1;
        int          first_en  = -1;
        int          done_c    = -1;
        int          done_cnt  = 0;
        bit          other_gnt = 1'b0;
        logic [31:0] cap_addr  = '0;
        logic [31:0] cap_wdata = '0;
        logic [31:0] cap_rdata = '0;
        logic [1:0]  cap_strb  = '0;
        logic        cap_wr    = 1'b0;
        string       pfx;
        pfx = $sformatf("vec%0d", idx);
        cycle();
        auto_resp = 1'b1;
        resp_lat  = v.lat;
        m_rdata   = v.mdata;
        drive_port(~v.port, 1'b0, 1'b1, 32'hFFFF_FFF0, 32'hCCCC_CCCC, 2'b11);
        drive_port(v.port, 1'b1, v.wr, v.addr, v.wdata, v.strb);
        for (int c = 1; c <= 20; c++) begin
            logic mine_gnt, mine_done, their_gnt;
            cycle();
            mine_gnt  = v.port ? gnt1  : gnt0;
            mine_done = v.port ? done1 : done0;
            their_gnt = v.port ? gnt0  : gnt1;
            if (mine_gnt && first_gnt < 0) first_gnt = c;
            if (their_gnt) other_gnt = 1'b1;
            if (m_en && first_en < 0) first_en = c;
            if (first_gnt > 0 && done_c < 0)
                drive_port(v.port, 1'b1, v.wr, ~v.addr, ~v.wdata, ~v.strb);
            if (mine_done) begin
                done_cnt++;
                if (done_c < 0) begin
                    done_c    = c;
                    cap_addr  = m_addr;
                    cap_wdata = m_wdata;
                    cap_strb  = m_strb;
                    cap_wr    = m_wr;
                    cap_rdata = rdata;
                    drive_port(v.port, 1'b0, v.wr, v.addr, v.wdata, v.strb);
                end
            end
            if (done_c > 0 && c == done_c + 1)
                check({pfx, "_gnt_release"}, 32'(mine_gnt), 32'd0);
            if (done_c > 0 && c == done_c + 2) break;
        end
        check({pfx, "_gnt_cycle"},    first_gnt, 1);
        check({pfx, "_trans_en_cyc"}, first_en, 1);
        check({pfx, "_done_cycle"},   done_c, 1 + v.lat);
        check({pfx, "_done_count"},   done_cnt, 1);
        check({pfx, "_other_gnt"},    32'(other_gnt), 32'd0);
        check({pfx, "_m_addr"},       cap_addr, v.addr);
        check({pfx, "_m_wdata"},      cap_wdata, v.wdata);
        check({pfx, "_m_strb"},       32'(cap_strb), 32'(v.strb));
        check({pfx, "_m_wr"},         32'(cap_wr), 32'(v.wr));
        check({pfx, "_rdata"},        cap_rdata, v.exp_rdata);
    endtask

    task automatic rnd_port(input logic x);
        logic cur;
        cur = x ? req1 : req0;
        if (cur && active && owner_m == x && k == g + L) begin
            drive_port(x, 1'b0, p_wr[x], p_addr[x], p_wdata[x], p_strb[x]);
        end else if (!cur && $urandom_range(0, 3) == 0) begin
            p_wr[x]    = 1'($urandom_range(0, 1));
            p_addr[x]  = $urandom;
            p_wdata[x] = $urandom;
            p_strb[x]  = 2'($urandom_range(0, 3));
            drive_port(x, 1'b1, p_wr[x], p_addr[x], p_wdata[x], p_strb[x]);
        end else if (cur && active && owner_m == x) begin
            drive_port(x, 1'b1, 1'($urandom_range(0, 1)), $urandom, $urandom, 2'($urandom_range(0, 3)));
        end
    endtask

    initial begin
        int          ord_m[4];
        int          ord_f[4];
        int          nm, nf, first_gnt, done_c, en_cycles;
        bit          stray;
        logic        err_at_done;
        logic [31:0] cap_rdata;
        logic [6:0]  exp_ctl;
        bit          in_wait;

        vecs[0] = '{1'b0, 1'b0, 32'h0000_0010, 32'h0000_0000, 2'b00, 2, 32'hA5A5_0001, 32'hA5A5_0001};
        vecs[1] = '{1'b1, 1'b1, 32'h2000_0004, 32'h1234_5678, 2'b01, 3, 32'hFFFF_0000, 32'hA5A5_0001};
        vecs[2] = '{1'b1, 1'b0, 32'h0000_0044, 32'h0000_0000, 2'b00, 4, 32'h0BAD_F00D, 32'h0BAD_F00D};
        vecs[3] = '{1'b0, 1'b1, 32'h0000_0100, 32'hCAFE_0042, 2'b11, 2, 32'h1111_2222, 32'h0BAD_F00D};
        vecs[4] = '{1'b0, 1'b0, 32'h0000_0200, 32'h0000_0000, 2'b10, 5, 32'h0000_5A5A, 32'h0000_5A5A};

        rst_n = 1'b0;
        req0 = 1'b0; req1 = 1'b0; wr0 = 1'b0; wr1 = 1'b0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0; strb0 = '0; strb1 = '0;
        m_done = 1'b0; fp_m_done = 1'b0; m_rdata = '0;
        #1;
        check("reset_ctl",   32'(ctl()), 32'd0);
        check("reset_rdata", rdata, 32'd0);
        check("reset_m_pay", m_addr | m_wdata | 32'(m_strb) | 32'(m_wr), 32'd0);
        do_reset();

        // Single-requester table.
        for (int i = 0; i < 5; i++) run_vec(i, vecs[i]);

        // Stray trans_done while idle.
        auto_resp = 1'b0;
        m_rdata   = 32'h9999_9999;
        cycle();
        m_done = 1'b1;
        cycle();
        m_done = 1'b0;
        for (int c = 0; c < 3; c++) begin
            cycle();
            check("idle_done_ctl", 32'(ctl()), 32'd0);
        end
        check("idle_done_rdata", rdata, vecs[4].exp_rdata);

        // Both requesters held for four transfers, both priority modes.
        do_reset();
        auto_resp = 1'b1;
        resp_lat  = 2;
        m_rdata   = 32'h7777_0000;
        drive_port(1'b0, 1'b1, 1'b0, 32'h40, 32'h0, 2'b00);
        drive_port(1'b1, 1'b1, 1'b0, 32'h80, 32'h0, 2'b00);
        nm = 0;
        nf = 0;
        for (int c = 0; c < 80 && (nm < 4 || nf < 4); c++) begin
            cycle();
            if ((done0 || done1) && nm < 4) begin ord_m[nm] = int'(done1); nm++; end
            if ((fp_done0 || fp_done1) && nf < 4) begin ord_f[nf] = int'(fp_done1); nf++; end
        end
        check("rr_count", nm, 4);
        check("fp_count", nf, 4);
        for (int i = 0; i < 4; i++) begin
            if (i < nm) check($sformatf("rr_order%0d", i), ord_m[i], i % 2);
            if (i < nf) check($sformatf("fp_order%0d", i), ord_f[i], 0);
        end
        req0 = 1'b0;
        req1 = 1'b0;
        repeat (10) cycle();

        // Asynchronous reset while waiting on the master.
        resp_lat = 1000;
        drive_port(1'b0, 1'b1, 1'b0, 32'h0000_0300, 32'h0, 2'b00);
        repeat (4) cycle();
        check("pre_reset_en", 32'(m_en), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("async_reset_ctl",   32'(ctl()), 32'd0);
        check("async_reset_rdata", rdata, 32'd0);
        check("async_reset_m_pay", m_addr | m_wdata | 32'(m_strb) | 32'(m_wr), 32'd0);
        @(negedge clk);
        rst_n    = 1'b1;
        en_cnt   = 0;
        resp_lat = 2;
        first_gnt = -1;
        done_c    = -1;
        stray     = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            cycle();
            if ((done0 || done1) && first_gnt < 0) stray = 1'b1;
            if (gnt0 && first_gnt < 0) first_gnt = c;
            if (done0 && done_c < 0) begin done_c = c; req0 = 1'b0; end
            if (done_c > 0 && c == done_c + 2) break;
        end
        check("post_reset_stray_done", 32'(stray), 32'd0);
        check("post_reset_gnt_cycle",  first_gnt, 1);
        check("post_reset_done_cycle", done_c, 3);

`ifdef APB_ARB_TIMEOUT_EN
        // Master never answers: watchdog ends the transfer after 8 WAIT cycles.
        auto_resp = 1'b0;
        m_done    = 1'b0;
        drive_port(1'b0, 1'b1, 1'b0, 32'h0000_0400, 32'h0, 2'b00);
        en_cycles   = 0;
        done_c      = -1;
        err_at_done = 1'b0;
        cap_rdata   = '0;
        for (int c = 1; c <= 40; c++) begin
            cycle();
            if (m_en) en_cycles++;
            if (done0) begin
                done_c      = c;
                err_at_done = err0;
                cap_rdata   = rdata;
                req0        = 1'b0;
                break;
            end
        end
        check("wd_en_cycles",  en_cycles, 9);
        check("wd_done_cycle", done_c, 10);
        check("wd_err0",       32'(err_at_done), 32'd1);
        check("wd_rdata",      cap_rdata, 32'hDEAD_BEEF);
        repeat (3) cycle();
`endif

        // Randomized traffic against the timeline model.
        do_reset();
        auto_resp = 1'b0;
        k = 0; g = 0; L = 0; free_from = 0; active = 1'b0;
        owner_m = 1'b0; ptr_m = 1'b0;
        e_wr = 1'b0; e_addr = '0; e_wdata = '0; e_strb = '0; e_rdata = '0;
        for (int x = 0; x < 2; x++) begin
            p_wr[x] = 1'b0; p_addr[x] = '0; p_wdata[x] = '0; p_strb[x] = '0;
        end
        for (int it = 0; it < 600; it++) begin
            exp_ctl = {active && owner_m, active && !owner_m,
                       active && owner_m && k == g + L, active && !owner_m && k == g + L,
                       2'b00, active && k < g + L};
            check("rnd_ctl",   32'(ctl()), 32'(exp_ctl));
            check("rnd_m_wr",  32'(m_wr), 32'(e_wr));
            check("rnd_addr",  m_addr, e_addr);
            check("rnd_wdata", m_wdata, e_wdata);
            check("rnd_strb",  32'(m_strb), 32'(e_strb));
            check("rnd_rdata", rdata, e_rdata);

            rnd_port(1'b0);
            rnd_port(1'b1);
            in_wait = active && k >= g + 1 && k < g + L;
            if (active && k + 1 == g + L)
                m_done = 1'b1;
            else if (!in_wait && (!active || k == g + L))
                m_done = ($urandom_range(0, 3) == 0);
            else
                m_done = 1'b0;
            m_rdata = $urandom;

            @(posedge clk);
            k++;
            if (active && k == g + L) begin
                if (!e_wr) e_rdata = m_rdata;
                ptr_m = ~owner_m;
            end
            if (active && k == g + L + 1) begin
                active    = 1'b0;
                free_from = k + 1;
            end
            if (!active && k >= free_from && (req0 || req1)) begin
                owner_m = (req0 && req1) ? ptr_m : req1;
                g       = k;
                L       = $urandom_range(2, 5);
                active  = 1'b1;
                e_wr    = p_wr[owner_m];
                e_addr  = p_addr[owner_m];
                e_wdata = p_wdata[owner_m];
                e_strb  = p_strb[owner_m];
            end
            @(negedge clk);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
